// File: rtl/npu_act_pkg.sv
`default_nettype none
// ============================================================================
// Module   : npu_act_pkg
// Purpose  : Shared types and fixed-point helpers for the activation stage.
// Revision : 1.0 - initial release
// ============================================================================
package npu_act_pkg;

   // Per-beat activation mode, shared by every lane of the beat.
   typedef enum logic [1:0] {
      ACT_SIGMOID = 2'b00,
      ACT_TANH    = 2'b01,
      ACT_RELU    = 2'b10,
      ACT_BYPASS  = 2'b11
   } act_mode_e;

   // Fixed-point 1.0 with 'of' fractional bits.
   function automatic longint act_one(input int of);
      return longint'(1) << of;
   endfunction

   // Right shift that maps the magnitude range [0, 2^SAT_LOG2) onto the LUT.
   function automatic int act_sh(input int ifb, input int sat_log2, input int aw);
      return ifb + sat_log2 - aw;
   endfunction

   // Saturation threshold 2^SAT_LOG2 expressed with 'ifb' fractional bits.
   function automatic longint act_sat_thr(input int ifb, input int sat_log2);
      return longint'(1) << (ifb + sat_log2);
   endfunction

endpackage
`default_nettype wire

// File: rtl/activation_lut.sv
`default_nettype none
// ============================================================================
// Module   : activation_lut
// Purpose  : Per-lane sigmoid ROM, registered address and registered output
//            (two-cycle read), both gated by the pipeline advance enable.
// Revision : 1.0 - initial release
// ============================================================================
module activation_lut #(
   parameter int    DW          = 32,
   parameter int    OF          = 19,
   parameter int    SAMPLES     = 512,
   parameter int    AW          = $clog2(SAMPLES),
   parameter int    SAT_LOG2    = 3,
   parameter string RTL_DIR     = "./",
   parameter string TARGET_FPGA = "generic"
) (
   input  logic          clk_i,
   input  logic          en_i,
   input  logic [AW-1:0] addr_i,
   output logic [DW-1:0] data_o
);

   // Table entry a holds round(2^OF * sigmoid(a * 2^SAT_LOG2 / SAMPLES)).
   // exp(-step) comes from a Taylor series in Q30; successive entries reuse
   // the running product so the whole table is built with integer math.
   function automatic logic [SAMPLES*DW-1:0] build_rom();
      logic [SAMPLES*DW-1:0] rom;
      longint unsigned step, term, e1, e, num, den;
      rom  = '0;
      step = 64'd1 << (30 + SAT_LOG2 - AW);
      term = 64'd1 << 30;
      e1   = term;
      for (int k = 1; k < 12; k++) begin
         term = ((term * step) >> 30) / 64'(k);
         if ((k % 2) == 1) e1 = e1 - term;
         else              e1 = e1 + term;
      end
      e = 64'd1 << 30;
      for (int a = 0; a < SAMPLES; a++) begin
         den = (64'd1 << 30) + e;
         num = (64'd1 << (OF + 30)) + (den >> 1);
         rom[a*DW +: DW] = DW'(num / den);
         e = (e * e1) >> 30;
      end
      return rom;
   endfunction

   localparam logic [SAMPLES*DW-1:0] ROM_C = build_rom();

   logic [AW-1:0] addr_q;

   // Address register: first cycle of the synchronous read.
   always_ff @(posedge clk_i) begin
      if (en_i) addr_q <= addr_i;
   end

   if (TARGET_FPGA == "generic" || RTL_DIR == "") begin : g_generic
      logic [DW-1:0] data_q;
      // Output register: second cycle of the synchronous read.
      always_ff @(posedge clk_i) begin
         if (en_i) data_q <= ROM_C[addr_q*DW +: DW];
      end
      assign data_o = data_q;
   end else begin : g_device
      (* romstyle = "M20K" *) logic [DW-1:0] data_q;
      // Output register mapped onto the block-RAM output stage.
      always_ff @(posedge clk_i) begin
         if (en_i) data_q <= ROM_C[addr_q*DW +: DW];
      end
      assign data_o = data_q;
   end

endmodule
`default_nettype wire

// File: rtl/activation_unit.sv
`default_nettype none
// ============================================================================
// Module   : activation_unit
// Purpose  : Multi-lane streaming activation (sigmoid/tanh/relu/bypass),
//            4-stage pipeline with a single global advance enable.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef RTL_DIR
`define RTL_DIR "./"
`endif
`ifndef TARGET_FPGA
`define TARGET_FPGA "generic"
`endif

module activation_unit
   import npu_act_pkg::*;
#(
   parameter int    LANES       = 4,
   parameter int    DW          = 32,
   parameter int    IF          = 19,
   parameter int    OF          = 19,
   parameter int    SAMPLES     = 512,
   parameter int    AW          = $clog2(SAMPLES),
   parameter int    SAT_LOG2    = 3,
   parameter string RTL_DIR     = `RTL_DIR,
   parameter string TARGET_FPGA = `TARGET_FPGA
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [1:0]          in_mode_i,
   input  logic [LANES*DW-1:0] in_data_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [LANES*DW-1:0] out_data_o
);

   localparam int            SH   = act_sh(IF, SAT_LOG2, AW);
   localparam int            RSH  = IF - OF;
   localparam logic [DW-1:0] THR  = DW'(act_sat_thr(IF, SAT_LOG2));
   localparam logic [DW-1:0] ONE  = DW'(act_one(OF));
   localparam logic [DW-1:0] AMAX = DW'(SAMPLES - 1);
   localparam logic [DW-1:0] XMIN = {1'b1, {(DW-1){1'b0}}};

   logic en;
   logic v1_q, v2_q, v3_q, out_valid_q;
   act_mode_e mode1_q, mode2_q, mode3_q;
   logic [LANES-1:0] neg1_q, neg2_q, neg3_q, big1_q, big2_q, big3_q;
   logic [LANES-1:0] neg1_d, big1_d, big2_d;
   logic [LANES-1:0][DW-1:0] x1_q, x2_q, x3_q, a2_q, a2_d;
   logic [LANES-1:0][DW-1:0] lut_data, out_data_q, out_data_d;
   logic [LANES-1:0][AW-1:0] addr_d;

   assign en          = !out_valid_q || out_ready_i;
   assign in_ready_o  = en;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

   // S1 combinational: sign, magnitude, tanh doubling and overflow detection.
   always_comb begin : s1_comb
      logic [DW-1:0] xs, mag;
      neg1_d = '0;
      big1_d = '0;
      a2_d   = '0;
      for (int i = 0; i < LANES; i++) begin
         xs        = in_data_i[i*DW +: DW];
         neg1_d[i] = xs[DW-1];
         mag       = xs[DW-1] ? (~xs + 1'b1) : xs;
         big1_d[i] = (xs == XMIN);
         if (act_mode_e'(in_mode_i) == ACT_TANH) begin
            big1_d[i] = big1_d[i] | mag[DW-1];
            a2_d[i]   = mag << 1;
         end else begin
            a2_d[i]   = mag;
         end
      end
   end

   // S2 combinational: saturation compare and rounded, clamped LUT address.
   always_comb begin : s2_comb
      logic [DW-1:0] hi;
      big2_d = '0;
      addr_d = '0;
      for (int i = 0; i < LANES; i++) begin
         big2_d[i] = big1_q[i] | (a2_q[i] > THR);
         hi        = (a2_q[i] >> SH) + {{(DW-1){1'b0}}, a2_q[i][SH-1]};
         addr_d[i] = (hi > AMAX) ? AMAX[AW-1:0] : hi[AW-1:0];
      end
   end

   // One ROM per lane; its two internal registers form S2 and S3.
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      activation_lut #(
         .DW(DW), .OF(OF), .SAMPLES(SAMPLES), .AW(AW), .SAT_LOG2(SAT_LOG2),
         .RTL_DIR(RTL_DIR), .TARGET_FPGA(TARGET_FPGA)
      ) u_lut (
         .clk_i  (clk_i),
         .en_i   (en),
         .addr_i (addr_d[g]),
         .data_o (lut_data[g])
      );
   end

   // S4 combinational: mode-specific post-processing of the LUT value.
   always_comb begin : s4_comb
      logic [DW-1:0] t;
      out_data_d = '0;
      for (int i = 0; i < LANES; i++) begin
         t = (lut_data[i] << 1) - ONE;
         case (mode3_q)
            ACT_SIGMOID: out_data_d[i] = big3_q[i] ? (neg3_q[i] ? '0 : ONE)
                                                   : (neg3_q[i] ? ONE - lut_data[i] : lut_data[i]);
            ACT_TANH:    out_data_d[i] = big3_q[i] ? (neg3_q[i] ? '0 - ONE : ONE)
                                                   : (neg3_q[i] ? '0 - t : t);
            ACT_RELU:    out_data_d[i] = neg3_q[i] ? '0 : DW'($signed(x3_q[i]) >>> RSH);
            default:     out_data_d[i] = x3_q[i];
         endcase
      end
   end

   // Pipeline registers: every stage advances together on en, or holds.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         v3_q        <= 1'b0;
         out_valid_q <= 1'b0;
         mode1_q     <= ACT_SIGMOID;
         mode2_q     <= ACT_SIGMOID;
         mode3_q     <= ACT_SIGMOID;
         neg1_q      <= '0;
         neg2_q      <= '0;
         neg3_q      <= '0;
         big1_q      <= '0;
         big2_q      <= '0;
         big3_q      <= '0;
         x1_q        <= '0;
         x2_q        <= '0;
         x3_q        <= '0;
         a2_q        <= '0;
         out_data_q  <= '0;
      end else if (en) begin
         v1_q        <= in_valid_i;
         mode1_q     <= act_mode_e'(in_mode_i);
         neg1_q      <= neg1_d;
         big1_q      <= big1_d;
         x1_q        <= in_data_i;
         a2_q        <= a2_d;
         v2_q        <= v1_q;
         mode2_q     <= mode1_q;
         neg2_q      <= neg1_q;
         big2_q      <= big2_d;
         x2_q        <= x1_q;
         v3_q        <= v2_q;
         mode3_q     <= mode2_q;
         neg3_q      <= neg2_q;
         big3_q      <= big2_q;
         x3_q        <= x2_q;
         out_valid_q <= v3_q;
         out_data_q  <= out_data_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_activation_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_activation_unit
// Purpose  : Scoreboard bench for activation_unit: directed vectors, reset
//            flush, rounding clamp and a randomly back-pressured stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_activation_unit;

   localparam int LANES = 4;
   localparam int DW    = 32;
   localparam int ONE   = 524288;

   typedef struct {
      logic [LANES*DW-1:0] data;
      logic [LANES*4-1:0]  tol;
      int                  id;
   } exp_t;

   logic                clk_i = 1'b0;
   logic                rst_ni;
   logic                in_valid_i;
   logic                in_ready_o;
   logic [1:0]          in_mode_i;
   logic [LANES*DW-1:0] in_data_i;
   logic                out_valid_o;
   logic                out_ready_i;
   logic [LANES*DW-1:0] out_data_o;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_popped = 0;
   int   beat_id  = 0;
   bit   bp_on    = 0;

   activation_unit dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_mode_i   (in_mode_i),
      .in_data_i   (in_data_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input longint got, input longint req);
      n_checks++;
      if (got != req) begin
         n_errors++;
         $display("FAIL %s: got %0d, required %0d", nm, got, req);
      end
   endtask

   // Ideal sigmoid sample at table address addr, rounded to Q19.
   function automatic int lref(input int addr);
      real t;
      t = real'(addr) * 8.0 / 512.0;
      return int'($floor(524288.0 / (1.0 + $exp(-t)) + 0.5));
   endfunction

   // Reference for one lane, with the allowed deviation from the ideal LUT.
   function automatic void ref_lane(input logic [1:0] m, input logic [31:0] xin,
                                    output int y, output int tol);
      longint x, a, a2;
      bit     neg, big;
      int     addr, l, t;
      x    = longint'($signed(xin));
      neg  = (x < 0);
      a    = neg ? -x : x;
      a2   = (m == 2'b01) ? 2 * a : a;
      big  = (a2 > (longint'(1) << 22));
      addr = (a2 > 64'd8388608) ? 511 : int'((a2 + 4096) >>> 13);
      if (addr > 511) addr = 511;
      l    = lref(addr);
      t    = 2 * l - ONE;
      tol  = 0;
      case (m)
         2'b00: if (big) y = neg ? 0 : ONE; else begin y = neg ? ONE - l : l; tol = 1; end
         2'b01: if (big) y = neg ? -ONE : ONE; else begin y = neg ? -t : t; tol = 2; end
         2'b10: y = neg ? 0 : int'(xin);
         default: y = int'(xin);
      endcase
   endfunction

   function automatic logic [127:0] pack4(input int l0, input int l1, input int l2, input int l3);
      return {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
   endfunction

   // Present one beat at posedge+2 and hold it until accepted.
   task automatic send(input logic [1:0] m, input logic [127:0] d,
                       input logic [127:0] e, input logic [15:0] tol, input bit push);
      exp_t x;
      bit   ok;
      int   waited;
      in_valid_i = 1'b1;
      in_mode_i  = m;
      in_data_i  = d;
      if (push) begin
         x.data = e; x.tol = tol; x.id = beat_id++;
         sb.push_back(x);
      end
      ok = 0;
      waited = 0;
      while (!ok && waited < 200) begin
         @(negedge clk_i);
         ok = in_ready_o;
         @(posedge clk_i);
         #2;
         waited++;
      end
      if (!ok) chk("send timeout", 0, 1);
      in_valid_i = 1'b0;
   endtask

   // Beat with every lane computed by the reference model.
   task automatic send_model(input logic [1:0] m, input logic [127:0] d);
      logic [127:0] e;
      logic [15:0]  tl;
      int           y, t;
      for (int i = 0; i < LANES; i++) begin
         ref_lane(m, d[i*DW +: DW], y, t);
         e[i*DW +: DW] = 32'(y);
         tl[i*4 +: 4]  = 4'(t);
      end
      send(m, d, e, tl, 1'b1);
   endtask

   // Monitor: scoreboard pop on every transfer, plus stall-hold checks.
   initial begin : monitor
      bit                  stall_q = 0;
      logic [LANES*DW-1:0] held_q  = '0;
      exp_t                e;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            stall_q = 0;
         end else begin
            if (stall_q) begin
               chk("stall out_valid held", out_valid_o, 1);
               n_checks++;
               if (out_data_o !== held_q) begin
                  n_errors++;
                  $display("FAIL stall data held: got %h, required %h", out_data_o, held_q);
               end
            end
            if (out_valid_o && !out_ready_i) begin
               chk("stall in_ready", in_ready_o, 0);
               stall_q = 1;
               held_q  = out_data_o;
            end else begin
               stall_q = 0;
            end
            if (out_valid_o && out_ready_i) begin
               if (sb.size() == 0) begin
                  chk("unexpected output beat", 1, 0);
               end else begin
                  e = sb.pop_front();
                  n_popped++;
                  for (int i = 0; i < LANES; i++) begin
                     int got, req, tl, diff;
                     got  = int'(out_data_o[i*DW +: DW]);
                     req  = int'(e.data[i*DW +: DW]);
                     tl   = int'(e.tol[i*4 +: 4]);
                     diff = (got > req) ? got - req : req - got;
                     n_checks++;
                     if (diff > tl) begin
                        n_errors++;
                        $display("FAIL beat%0d lane%0d: got %0d, required %0d (+/-%0d)",
                                 e.id, i, got, req, tl);
                     end
                  end
               end
            end
         end
      end
   end

   // Random 50% back-pressure while bp_on is set.
   initial begin : backpressure
      wait (bp_on);
      while (bp_on) begin
         @(posedge clk_i);
         #1;
         out_ready_i = 1'($urandom_range(0, 1));
      end
      out_ready_i = 1'b1;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "simulation timeout");
   end

   initial begin : main
      int l64, l511, lat, base;
      l64  = lref(64);
      l511 = lref(511);
      rst_ni = 1'b0; in_valid_i = 1'b0; in_mode_i = 2'b00; in_data_i = '0; out_ready_i = 1'b1;

      // Reset state.
      repeat (3) begin
         @(negedge clk_i);
         chk("reset out_valid", out_valid_o, 0);
      end
      chk("reset out_data", longint'(out_data_o == '0), 1);
      @(posedge clk_i); #2 rst_ni = 1'b1;
      @(posedge clk_i); #1;
      chk("in_ready after release", in_ready_o, 1);
      #1;

      // Two beats in flight, then a 3-cycle reset: nothing may come out.
      send(2'b11, pack4(1, 2, 3, 4), '0, '0, 1'b0);
      send(2'b11, pack4(5, 6, 7, 8), '0, '0, 1'b0);
      rst_ni = 1'b0;
      repeat (3) begin
         @(negedge clk_i);
         chk("flush out_valid in reset", out_valid_o, 0);
      end
      @(posedge clk_i); #2 rst_ni = 1'b1;
      @(posedge clk_i); #1;
      chk("in_ready after flush release", in_ready_o, 1);
      repeat (6) begin
         @(negedge clk_i);
         chk("flush no stale beat", out_valid_o, 0);
      end
      @(posedge clk_i); #2;

      // Sigmoid beat with latency measurement from presentation.
      in_valid_i = 1'b1; in_mode_i = 2'b00;
      in_data_i  = pack4(0, 524288, -524288, 5242880);
      sb.push_back('{data: pack4(262144, l64, ONE - l64, ONE), tol: 16'h0110, id: beat_id++});
      lat = 0;
      while (lat < 12) begin
         @(posedge clk_i); lat++;
         #1;
         if (lat == 1) in_valid_i = 1'b0;
         if (out_valid_o) break;
      end
      chk("sigmoid latency", lat, 4);
      #1;

      // Tanh: 0.5 doubles to 1.0 (address 64); -2^31 forces saturation.
      send(2'b01, pack4(0, -5242880, 262144, int'(32'h8000_0000)),
           pack4(0, -ONE, 2 * l64 - ONE, -ONE), 16'h0200, 1'b1);

      // Relu / bypass alternating with sigmoid, back-to-back.
      send(2'b10, pack4(-5, 7, 32'h7FFF_FFFF, -1), pack4(0, 7, 32'h7FFF_FFFF, 0), '0, 1'b1);
      send(2'b00, pack4(0, 524288, -524288, 5242880),
           pack4(262144, l64, ONE - l64, ONE), 16'h0110, 1'b1);
      send(2'b11, pack4(-5, 7, 32'h7FFF_FFFF, -1), pack4(-5, 7, 32'h7FFF_FFFF, -1), '0, 1'b1);
      send(2'b00, pack4(0, 524288, -524288, 5242880),
           pack4(262144, l64, ONE - l64, ONE), 16'h0110, 1'b1);

      // Rounding clamp near 8.0: every lane must read address 511.
      send(2'b00, pack4(4194303, 4190208, -4194303, 4194304),
           pack4(l511, l511, ONE - l511, l511), 16'h1111, 1'b1);

      for (int c = 0; c < 100 && sb.size() != 0; c++) @(posedge clk_i);
      chk("directed drain", sb.size(), 0);
      #2;

      // Back-pressured stream of 20 model-checked beats.
      base  = n_popped;
      bp_on = 1;
      for (int b = 0; b < 20; b++) begin
         logic [127:0] d;
         for (int i = 0; i < 3; i++)
            d[i*DW +: DW] = 32'(int'($urandom_range(0, 10485760)) - 5242880);
         d[3*DW +: DW] = $urandom;
         send_model(2'($urandom_range(0, 3)), d);
      end
      bp_on = 0;
      for (int c = 0; c < 500 && sb.size() != 0; c++) @(posedge clk_i);
      chk("stream drain", sb.size(), 0);
      chk("stream beat count", n_popped - base, 20);

      repeat (4) @(posedge clk_i);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
